// File: rtl/go_timer.sv
// go_timer: two-player Go clock with main time and Japanese byo-yomi periods.
// Optional feature: define GO_TIMER_WARN_EN to enable the low-time warn output.
`default_nettype none

module go_timer #(
  parameter int MAIN_SECONDS = 600,
  parameter int BYO_SECONDS  = 30,
  parameter int BYO_PERIODS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        start,
  input  logic        pause,
  input  logic        move_done,
  output logic        cur_player,
  output logic [12:0] black_time,
  output logic [12:0] white_time,
  output logic [2:0]  black_periods,
  output logic [2:0]  white_periods,
  output logic        black_byo,
  output logic        white_byo,
  output logic        running,
  output logic        timeout,
  output logic        loser,
  output logic        warn
);

  localparam logic [12:0] MAIN_T  = 13'(MAIN_SECONDS);
  localparam logic [12:0] BYO_T   = 13'(BYO_SECONDS);
  localparam logic [2:0]  BYO_P   = 3'(BYO_PERIODS);
  localparam logic        HAS_BYO = (BYO_PERIODS > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t state;

  logic [12:0] act_time;
  logic [12:0] upd_time;
  logic        act_byo;
  logic        upd_byo;
  logic [2:0]  act_per;
  logic [2:0]  upd_per;
  logic        expire;

  // Active player's counters after this cycle's tick and move; the tick is
  // applied first so a move in the same cycle reloads the post-tick phase.
  always_comb begin
    act_time = cur_player ? white_time    : black_time;
    act_byo  = cur_player ? white_byo     : black_byo;
    act_per  = cur_player ? white_periods : black_periods;
    upd_time = act_time;
    upd_byo  = act_byo;
    upd_per  = act_per;
    expire   = 1'b0;
    if (tick_1hz) begin
      if (act_time > 13'd1) begin
        upd_time = act_time - 13'd1;
      end else if (!act_byo && HAS_BYO) begin
        upd_byo  = 1'b1;
        upd_time = BYO_T;
        upd_per  = BYO_P;
      end else if (act_byo && (act_per > 3'd1)) begin
        upd_per  = act_per - 3'd1;
        upd_time = BYO_T;
      end else begin
        upd_time = 13'd0;
        expire   = 1'b1;
      end
    end
    if (move_done && !expire && upd_byo) begin
      upd_time = BYO_T;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cur_player    <= 1'b0;
      black_time    <= MAIN_T;
      white_time    <= MAIN_T;
      black_periods <= 3'd0;
      white_periods <= 3'd0;
      black_byo     <= 1'b0;
      white_byo     <= 1'b0;
      running       <= 1'b0;
      timeout       <= 1'b0;
      loser         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_PAUSED: begin
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (cur_player) begin
            white_time    <= upd_time;
            white_byo     <= upd_byo;
            white_periods <= upd_per;
          end else begin
            black_time    <= upd_time;
            black_byo     <= upd_byo;
            black_periods <= upd_per;
          end
          if (expire) begin
            state   <= S_OVER;
            running <= 1'b0;
            timeout <= 1'b1;
            loser   <= cur_player;
          end else begin
            if (move_done) begin
              cur_player <= ~cur_player;
            end
            if (pause) begin
              state   <= S_PAUSED;
              running <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef GO_TIMER_WARN_EN
  logic        nx_run;
  logic        nx_byo;
  logic [12:0] nx_time;

  // Warn tracks the values the counters take on this edge, including a hand-over.
  always_comb begin
    nx_run  = running;
    nx_time = act_time;
    nx_byo  = act_byo;
    case (state)
      S_IDLE, S_PAUSED: begin
        if (start) nx_run = 1'b1;
      end
      S_RUN: begin
        nx_time = upd_time;
        nx_byo  = upd_byo;
        if (expire) begin
          nx_run = 1'b0;
        end else begin
          if (pause) nx_run = 1'b0;
          if (move_done) begin
            nx_time = cur_player ? black_time : white_time;
            nx_byo  = cur_player ? black_byo  : white_byo;
          end
        end
      end
      default: nx_run = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warn <= 1'b0;
    end else begin
      warn <= nx_run & nx_byo & (nx_time <= 13'd10);
    end
  end
`else
  assign warn = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_go_timer.sv
// tb_go_timer: two go_timer instances (default and short timings) share stimulus
// and are checked every cycle against a per-instance behavioural clock model.
`default_nettype none

module tb_go_timer;

  logic clk = 1'b0;
  logic rst, start, pause, tick, mv;

  logic        cp  [2];
  logic [12:0] bt  [2];
  logic [12:0] wt  [2];
  logic [2:0]  bpd [2];
  logic [2:0]  wpd [2];
  logic        bb  [2];
  logic        wb  [2];
  logic        run [2];
  logic        tmo [2];
  logic        los [2];
  logic        wrn [2];

  int n_checks = 0;
  int n_errors = 0;

  int P_MAIN [2] = '{600, 3};
  int P_BYO  [2] = '{30, 5};
  int P_PER  [2] = '{3, 2};

  // model: mode 0 idle, 1 run, 2 paused, 3 over; [dut][player]
  int m_time [2][2];
  int m_byo  [2][2];
  int m_per  [2][2];
  int m_cur  [2];
  int m_mode [2];
  int m_tmo  [2];
  int m_los  [2];

  always #5 clk = ~clk;

  go_timer #(.MAIN_SECONDS(600), .BYO_SECONDS(30), .BYO_PERIODS(3)) u_dut0 (
    .clk(clk), .rst(rst), .tick_1hz(tick), .start(start), .pause(pause),
    .move_done(mv), .cur_player(cp[0]), .black_time(bt[0]), .white_time(wt[0]),
    .black_periods(bpd[0]), .white_periods(wpd[0]), .black_byo(bb[0]),
    .white_byo(wb[0]), .running(run[0]), .timeout(tmo[0]), .loser(los[0]),
    .warn(wrn[0])
  );

  go_timer #(.MAIN_SECONDS(3), .BYO_SECONDS(5), .BYO_PERIODS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tick_1hz(tick), .start(start), .pause(pause),
    .move_done(mv), .cur_player(cp[1]), .black_time(bt[1]), .white_time(wt[1]),
    .black_periods(bpd[1]), .white_periods(wpd[1]), .black_byo(bb[1]),
    .white_byo(wb[1]), .running(run[1]), .timeout(tmo[1]), .loser(los[1]),
    .warn(wrn[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int p = 0; p < 2; p++) begin
      m_time[d][p] = P_MAIN[d];
      m_byo[d][p]  = 0;
      m_per[d][p]  = 0;
    end
    m_cur[d]  = 0;
    m_mode[d] = 0;
    m_tmo[d]  = 0;
    m_los[d]  = 0;
  endtask

  task automatic model_step(input int d, input bit st, input bit pa, input bit tk, input bit mo);
    int p;
    bit expired;
    case (m_mode[d])
      0, 2: if (st) m_mode[d] = 1;
      1: begin
        p = m_cur[d];
        expired = 0;
        if (tk) begin
          if (m_time[d][p] > 1) begin
            m_time[d][p] -= 1;
          end else if (m_byo[d][p] == 0 && P_PER[d] > 0) begin
            m_byo[d][p]  = 1;
            m_time[d][p] = P_BYO[d];
            m_per[d][p]  = P_PER[d];
          end else if (m_byo[d][p] == 1 && m_per[d][p] > 1) begin
            m_per[d][p] -= 1;
            m_time[d][p] = P_BYO[d];
          end else begin
            m_time[d][p] = 0;
            m_tmo[d]  = 1;
            m_los[d]  = p;
            m_mode[d] = 3;
            expired   = 1;
          end
        end
        if (!expired) begin
          if (mo) begin
            if (m_byo[d][p] == 1) m_time[d][p] = P_BYO[d];
            m_cur[d] = 1 - p;
          end
          if (pa) m_mode[d] = 2;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_warn(input int d);
`ifdef GO_TIMER_WARN_EN
    int p = m_cur[d];
    return (m_mode[d] == 1 && m_byo[d][p] == 1 && m_time[d][p] <= 10) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d cur_player", d),    cp[d],  m_cur[d]);
      check($sformatf("d%0d black_time", d),    bt[d],  m_time[d][0]);
      check($sformatf("d%0d white_time", d),    wt[d],  m_time[d][1]);
      check($sformatf("d%0d black_periods", d), bpd[d], m_per[d][0]);
      check($sformatf("d%0d white_periods", d), wpd[d], m_per[d][1]);
      check($sformatf("d%0d black_byo", d),     bb[d],  m_byo[d][0]);
      check($sformatf("d%0d white_byo", d),     wb[d],  m_byo[d][1]);
      check($sformatf("d%0d running", d),       run[d], (m_mode[d] == 1) ? 1 : 0);
      check($sformatf("d%0d timeout", d),       tmo[d], m_tmo[d]);
      check($sformatf("d%0d loser", d),         los[d], m_los[d]);
      check($sformatf("d%0d warn", d),          wrn[d], exp_warn(d));
    end
  endtask

  task automatic cycle(input bit st, input bit pa, input bit tk, input bit mo);
    start = st; pause = pa; tick = tk; mv = mo;
    @(posedge clk);
    #1;
    start = 0; pause = 0; tick = 0; mv = 0;
    for (int d = 0; d < 2; d++) model_step(d, st, pa, tk, mo);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 0);
  endtask

  // Reset is raised between edges so its effect is seen without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    for (int d = 0; d < 2; d++) model_reset(d);
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
    check_all();
  endtask

  initial begin
    rst = 1; start = 0; pause = 0; tick = 0; mv = 0;
    for (int d = 0; d < 2; d++) model_reset(d);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset d0 black_time", bt[0], 600);
    rst = 0;

    // main time into byo-yomi and final expiry on the short instance
    cycle(1, 0, 0, 0);
    ticks(3);
    check("byo entry black_byo", bb[1], 1);
    check("byo entry black_time", bt[1], 5);
    check("byo entry black_periods", bpd[1], 2);
    ticks(2);
    check("5 ticks black_time", bt[0], 595);
    check("5 ticks white_time", wt[0], 600);
    check("5 ticks cur_player", cp[0], 0);
    ticks(3);
    check("period used black_periods", bpd[1], 1);
    check("period used black_time", bt[1], 5);
    ticks(5);
    check("expiry timeout", tmo[1], 1);
    check("expiry loser", los[1], 0);
    check("expiry running", run[1], 0);

    // pause freezes, start resumes, reset mid-run clears
    cycle(0, 1, 0, 0);
    ticks(4);
    check("paused black_time", bt[0], 587);
    cycle(1, 0, 0, 0);
    ticks(1);
    check("resumed black_time", bt[0], 586);
    do_reset();
    check("mid-run reset black_time", bt[0], 600);
    check("mid-run reset running", run[0], 0);

    // move in byo-yomi reloads mover's time
    cycle(1, 0, 0, 0);
    ticks(6);
    check("pre-move black_time", bt[1], 2);
    cycle(0, 0, 0, 1);
    check("byo move black_time", bt[1], 5);
    check("byo move cur_player", cp[1], 1);
    check("byo move white_time", wt[1], 3);
    check("byo move white_periods", wpd[1], 0);
    do_reset();

    // expiry beats a simultaneous move
    cycle(1, 0, 0, 0);
    ticks(12);
    check("last second black_time", bt[1], 1);
    cycle(0, 0, 1, 1);
    check("tick+move expiry timeout", tmo[1], 1);
    check("tick+move expiry cur_player", cp[1], 0);
    do_reset();

    // tick and move together in main time
    cycle(1, 0, 0, 0);
    ticks(593);
    check("pre tick+move black_time", bt[0], 7);
    cycle(0, 0, 1, 1);
    check("tick+move black_time", bt[0], 6);
    check("tick+move cur_player", cp[0], 1);
    do_reset();

    // warn threshold in byo-yomi
    cycle(1, 0, 0, 0);
    ticks(619);
    check("warn pre black_time", bt[0], 11);
    check("warn pre", wrn[0], 0);
    ticks(1);
`ifdef GO_TIMER_WARN_EN
    check("warn at 10", wrn[0], 1);
`else
    check("warn at 10", wrn[0], 0);
`endif
    do_reset();

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 12);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/go_timer.md
GO_TIMER -- requirements
Module: go_timer

Interface
REQ-001 SHALL have parameter MAIN_SECONDS, default 600: per-player main time in seconds (1..5999).
REQ-002 SHALL have parameter BYO_SECONDS, default 30: length of one byo-yomi period in seconds (1..255).
REQ-003 SHALL have parameter BYO_PERIODS, default 3: byo-yomi periods per player (0..7; 0 means no byo-yomi).
REQ-004 SHALL have port clk, input, 1: single system clock; all logic uses its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port tick_1hz, input, 1: one-cycle 1 Hz enable pulse, synchronous to clk, produced from the clock generator's 1 Hz output.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins or resumes the game.
REQ-008 SHALL have port pause, input, 1: one-cycle pulse that suspends counting.
REQ-009 SHALL have port move_done, input, 1: one-cycle pulse meaning the active player has placed a stone.
REQ-010 SHALL have port cur_player, output, 1: active player (0 = black, 1 = white).
REQ-011 SHALL have ports black_time and white_time, output, 13 each: remaining seconds in the current phase.
REQ-012 SHALL have ports black_periods and white_periods, output, 3 each: remaining byo-yomi periods.
REQ-013 SHALL have ports black_byo and white_byo, output, 1 each: player is in byo-yomi.
REQ-014 SHALL have ports running (1), timeout (1) and loser (1, valid when timeout is high), all outputs.
REQ-015 SHALL have port warn, output, 1: low-time warning (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, RUN, PAUSED and OVER; running SHALL be 1 only in RUN.
REQ-017 IDLE --start--> RUN; RUN --pause--> PAUSED; PAUSED --start--> RUN; RUN --expiry--> OVER; OVER SHALL be left only by reset.
REQ-018 In RUN, tick_1hz with active time > 1 SHALL decrement the active time by 1 in the same cycle.
REQ-019 In RUN, tick_1hz with active time == 1 SHALL apply the first matching rule: if not in byo-yomi and BYO_PERIODS > 0, set byo = 1, time = BYO_SECONDS, periods = BYO_PERIODS; if in byo-yomi and periods > 1, decrement periods and set time = BYO_SECONDS; otherwise set time = 0, timeout = 1, loser = cur_player, and go to OVER.
REQ-020 In RUN, move_done SHALL toggle cur_player; if the mover is in byo-yomi, the mover's time SHALL reload to BYO_SECONDS and the mover's periods SHALL be unchanged.
REQ-021 If tick_1hz and move_done arrive in the same cycle, the tick SHALL first be applied to the mover, then REQ-020; if that tick causes expiry, the expiry SHALL win and move_done SHALL be ignored.
REQ-022 If pause and move_done arrive in the same cycle, both SHALL take effect; if pause and tick_1hz arrive in the same cycle, the tick SHALL be applied first.
REQ-023 tick_1hz, move_done and pause SHALL be ignored in IDLE, PAUSED and OVER; start SHALL be ignored in RUN and OVER.
REQ-024 The idle player's counters SHALL never change.
REQ-025 Every output SHALL be registered, with a latency of one clk cycle from the input event.

Reset
REQ-026 While rst is high, the block SHALL be held in IDLE with: cur_player = 0, both times = MAIN_SECONDS, both periods = 0, byo flags = 0, running = 0, timeout = 0, loser = 0, warn = 0.
REQ-027 Reset asserted mid-game SHALL discard all game state immediately and asynchronously.

Configuration
REQ-028 With macro GO_TIMER_WARN_EN defined, warn SHALL be a registered output equal to running AND the active player's byo flag AND active time <= 10.
REQ-029 Without GO_TIMER_WARN_EN, warn SHALL be tied to 0 and no comparison logic SHALL be synthesized.

Verification
REQ-030 Defaults; rst, start, 5 ticks -> black_time = 595, white_time = 600, cur_player = 0.
REQ-031 MAIN_SECONDS = 3, BYO_SECONDS = 5, BYO_PERIODS = 2; start, 3 ticks -> black_byo = 1, black_time = 5, black_periods = 2; 5 more ticks -> black_periods = 1, black_time = 5; 5 more ticks -> timeout = 1, loser = 0, running = 0.
REQ-032 In byo-yomi with black_time = 2, issue move_done -> black_time = 5, cur_player = 1, white counters unchanged.
REQ-033 tick_1hz and move_done in the same cycle with black_time = 7 (main time) -> black_time = 6, cur_player = 1.
REQ-034 pause, then 4 ticks -> times frozen; start -> counting resumes; assert rst mid-RUN -> all outputs return to the reset values on the same edge.
REQ-035 GO_TIMER_WARN_EN defined, byo-yomi, black_time 11 -> 10 -> warn goes from 0 to 1; build without the macro -> warn = 0 throughout.
